// File: rtl/pipe_trace_monitor.sv
// rtl/pipe_trace_monitor.sv - pipeline trace monitor: WB/store capture into a trace FIFO plus saturating counters
// Optional shadow register file enabled by defining PIPE_TRACE_SHADOW_RF_EN.
module pipe_trace_monitor #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          wwreg,
  input  logic                          wm2reg,
  input  logic [REG_AW-1:0]             wdestReg,
  input  logic [DATA_W-1:0]             wr,
  input  logic [DATA_W-1:0]             wdo,
  input  logic                          mwmem,
  input  logic [DATA_W-1:0]             mr,
  input  logic [DATA_W-1:0]             mqb,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic                          trace_kind,
  output logic [DATA_W-1:0]             trace_addr,
  output logic [DATA_W-1:0]             trace_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              cycle_count,
  output logic [CNT_W-1:0]              wb_count,
  output logic [CNT_W-1:0]              store_count,
  output logic [CNT_W-1:0]              drop_count,
`ifdef PIPE_TRACE_SHADOW_RF_EN
  input  logic [REG_AW-1:0]             shadow_raddr,
  output logic [DATA_W-1:0]             shadow_rdata,
`endif
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic              mem_kind [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  logic          wb_ev, st_ev, pop;
  logic          push_wb, push_st;
  logic [LW:0]   free;
  logic [1:0]    ndrop;
  logic [PW-1:0] st_ptr;
  logic [DATA_W-1:0] wb_data;

  assign wb_ev   = enable && wwreg && (wdestReg != '0);
  assign st_ev   = enable && mwmem;
  assign wb_data = wm2reg ? wdo : wr;

  assign trace_valid = (level != '0);
  assign pop         = trace_valid && trace_ready;
  assign free        = (LW+1)'(FIFO_DEPTH) - {1'b0, level} + (LW+1)'(pop);

  // WB holds the older instruction, so it claims the first free slot.
  always_comb begin
    push_wb = 1'b0;
    push_st = 1'b0;
    if (wb_ev && free >= (LW+1)'(1)) push_wb = 1'b1;
    if (st_ev && free >= ((LW+1)'(1) + (LW+1)'(push_wb))) push_st = 1'b1;
  end

  assign ndrop  = 2'(wb_ev && !push_wb) + 2'(st_ev && !push_st);
  assign st_ptr = wr_ptr + PW'(push_wb);

  // Head outputs come straight from registered storage, blanked while empty.
  assign trace_kind = trace_valid ? mem_kind[rd_ptr] : 1'b0;
  assign trace_addr = trace_valid ? mem_addr[rd_ptr] : '0;
  assign trace_data = trace_valid ? mem_data[rd_ptr] : '0;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push_wb) begin
      mem_kind[wr_ptr] <= 1'b0;
      mem_addr[wr_ptr] <= DATA_W'(wdestReg);
      mem_data[wr_ptr] <= wb_data;
    end
    if (push_st) begin
      mem_kind[st_ptr] <= 1'b1;
      mem_addr[st_ptr] <= mr;
      mem_data[st_ptr] <= mqb;
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      cycle_count <= '0;
      wb_count    <= '0;
      store_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_wb) + PW'(push_st);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      level  <= level + LW'(push_wb) + LW'(push_st) - LW'(pop);
      if (enable) begin
        cycle_count <= sat_add(cycle_count, 2'd1);
        store_count <= sat_add(store_count, 2'(st_ev));
        wb_count    <= sat_add(wb_count, 2'(wb_ev));
        drop_count  <= sat_add(drop_count, ndrop);
        if (ndrop != 2'd0) overflow <= 1'b1;
      end
    end
  end

`ifdef PIPE_TRACE_SHADOW_RF_EN
  logic [DATA_W-1:0] shadow [2**REG_AW];

  // Tracks every WB write even when the trace FIFO drops it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_AW; i++) shadow[i] <= '0;
    end else if (wb_ev) begin
      shadow[wdestReg] <= wb_data;
    end
  end

  assign shadow_rdata = (shadow_raddr == '0) ? '0 : shadow[shadow_raddr];
`endif

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// tb/tb_pipe_trace_monitor.sv - directed self-checking bench for pipe_trace_monitor
module tb_pipe_trace_monitor;

  logic        clk = 1'b0;
  logic        rst_n, enable, wwreg, wm2reg, mwmem, trace_ready;
  logic [4:0]  wdestReg;
  logic [31:0] wr, wdo, mr, mqb;
  logic        trace_valid, trace_kind, overflow;
  logic [31:0] trace_addr, trace_data;
  logic [4:0]  fifo_level;
  logic [31:0] cycle_count, wb_count, store_count, drop_count;
`ifdef PIPE_TRACE_SHADOW_RF_EN
  logic [4:0]  shadow_raddr;
  logic [31:0] shadow_rdata;
`endif

  int tests = 0;
  int fails = 0;

  logic        exp_kind [$];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];

  always #5 clk = ~clk;

  pipe_trace_monitor dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wwreg(wwreg), .wm2reg(wm2reg), .wdestReg(wdestReg), .wr(wr), .wdo(wdo),
    .mwmem(mwmem), .mr(mr), .mqb(mqb),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_kind(trace_kind),
    .trace_addr(trace_addr), .trace_data(trace_data), .fifo_level(fifo_level),
    .cycle_count(cycle_count), .wb_count(wb_count), .store_count(store_count),
    .drop_count(drop_count),
`ifdef PIPE_TRACE_SHADOW_RF_EN
    .shadow_raddr(shadow_raddr), .shadow_rdata(shadow_rdata),
`endif
    .overflow(overflow)
  );

  task automatic idle_inputs();
    wwreg = 0; wm2reg = 0; wdestReg = 0; wr = 0; wdo = 0;
    mwmem = 0; mr = 0; mqb = 0; trace_ready = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 0; idle_inputs();
    step(); step();
    chk("rst_valid", 32'(trace_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_addr", trace_addr, 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst_n = 1; enable = 1;
    repeat (10) step();
    chk("idle_cycles", cycle_count, 10);
    chk("idle_wb", wb_count, 0);
    chk("idle_st", store_count, 0);
    chk("idle_drop", drop_count, 0);
    chk("idle_valid", 32'(trace_valid), 0);
    chk("idle_level", 32'(fifo_level), 0);
  endtask

  task automatic test_wb_event();
    wwreg = 1; wdestReg = 3; wm2reg = 0; wr = 32'h5; wdo = 32'h99;
    step();
    idle_inputs();
    chk("wb_valid", 32'(trace_valid), 1);
    chk("wb_kind", 32'(trace_kind), 0);
    chk("wb_addr", trace_addr, 3);
    chk("wb_data", trace_data, 5);
    chk("wb_count", wb_count, 1);
`ifdef PIPE_TRACE_SHADOW_RF_EN
    shadow_raddr = 3; #1;
    chk("shadow_r3", shadow_rdata, 5);
`endif
    wwreg = 1; wdestReg = 0; wr = 32'h77;
    step();
    idle_inputs();
    chk("r0_count", wb_count, 1);
    chk("r0_level", 32'(fifo_level), 1);
    trace_ready = 1;
    step();
    idle_inputs();
    chk("wb_pop_valid", 32'(trace_valid), 0);
  endtask

  task automatic test_dual();
    wwreg = 1; wdestReg = 7; wm2reg = 1; wdo = 32'hDEAD_BEEF; wr = 32'h1111;
    mwmem = 1; mr = 32'h40; mqb = 32'h12;
    step();
    idle_inputs();
    chk("dual_level", 32'(fifo_level), 2);
    chk("dual_h0_kind", 32'(trace_kind), 0);
    chk("dual_h0_addr", trace_addr, 7);
    chk("dual_h0_data", trace_data, 32'hDEAD_BEEF);
    trace_ready = 1;
    step();
    chk("dual_h1_kind", 32'(trace_kind), 1);
    chk("dual_h1_addr", trace_addr, 32'h40);
    chk("dual_h1_data", trace_data, 32'h12);
    step();
    idle_inputs();
    chk("dual_empty", 32'(fifo_level), 0);
  endtask

  task automatic test_full();
    for (int i = 0; i < 15; i++) begin
      mwmem = 1; mr = 32'(i); mqb = 32'h100 + 32'(i);
      if (i > 0) begin
        exp_kind.push_back(1); exp_addr.push_back(32'(i)); exp_data.push_back(32'h100 + 32'(i));
      end
      step();
    end
    idle_inputs();
    chk("fill_level", 32'(fifo_level), 15);
    chk("fill_ovf", 32'(overflow), 0);
    wwreg = 1; wdestReg = 9; wr = 32'hAA; mwmem = 1; mr = 32'h999; mqb = 32'h55;
    exp_kind.push_back(0); exp_addr.push_back(9); exp_data.push_back(32'hAA);
    step();
    idle_inputs();
    chk("near_full_level", 32'(fifo_level), 16);
    chk("near_full_drop", drop_count, 1);
    chk("near_full_ovf", 32'(overflow), 1);
    wwreg = 1; wdestReg = 10; wr = 32'hBB; mwmem = 1; mr = 32'h777; mqb = 32'h66;
    trace_ready = 1;
    exp_kind.push_back(0); exp_addr.push_back(10); exp_data.push_back(32'hBB);
    step();
    idle_inputs();
    chk("full_pop_level", 32'(fifo_level), 16);
    chk("full_pop_drop", drop_count, 2);
    chk("full_st_count", store_count, 18);
    chk("full_wb_count", wb_count, 4);
  endtask

  task automatic test_drain();
    trace_ready = 1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(trace_valid), 1);
      chk($sformatf("drain%0d_kind", k), 32'(trace_kind), 32'(exp_kind[k]));
      chk($sformatf("drain%0d_addr", k), trace_addr, exp_addr[k]);
      chk($sformatf("drain%0d_data", k), trace_data, exp_data[k]);
      step();
    end
    idle_inputs();
    chk("drain_valid_low", 32'(trace_valid), 0);
    chk("drain_level", 32'(fifo_level), 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      mwmem = 1; mr = 32'h200 + 32'(i); mqb = 32'(i);
      step();
    end
    idle_inputs();
    chk("mid_level", 32'(fifo_level), 5);
    rst_n = 0;
    step();
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_valid", 32'(trace_valid), 0);
    chk("mid_rst_cycles", cycle_count, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_st", store_count, 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
`ifdef PIPE_TRACE_SHADOW_RF_EN
    shadow_raddr = 3; #1;
    chk("shadow_rst", shadow_rdata, 0);
`endif
    rst_n = 1;
    step();
  endtask

  initial begin
`ifdef PIPE_TRACE_SHADOW_RF_EN
    shadow_raddr = 0;
`endif
    test_reset();
    test_wb_event();
    test_dual();
    test_full();
    test_drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
